// File: rtl/e_muldiv_unit_pkg.sv
// Shared constants for the E-stage multiply/divide unit.
// Holds the MDOp encodings, default busy-period lengths and the counter width.
// Imported by the interface, the arithmetic core, the unit top and the bench.
package e_muldiv_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Wide enough for any realistic busy period.
  localparam int CNT_W = 8;

endpackage

// File: rtl/e_muldiv_unit_if.sv
// E-stage md request/response bundle.
// master: pipeline side, drives Start/MDOp/A/B/Req and sees Busy/HI/LO/Out.
// slave: the md unit, the mirror image.
interface e_muldiv_unit_if;
  import e_muldiv_unit_pkg::*;

  logic        Start;
  md_op_t      MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  modport master (
    output Start, MDOp, A, B, Req,
    input  Busy, HI, LO, Out
  );

  modport slave (
    input  Start, MDOp, A, B, Req,
    output Busy, HI, LO, Out
  );

endinterface

// File: rtl/e_muldiv_unit_core.sv
// Pure combinational 64-bit multiply / divide datapath.
// Ports: op, a, b in; hi_res/lo_res (product halves or remainder/quotient) and
// div_zero (divisor is zero, result must not be committed) out.
module e_muldiv_unit_core
  import e_muldiv_unit_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic        signed_op;
  logic [63:0] ea;
  logic [63:0] eb;
  logic [63:0] db;
  logic [63:0] prod;

  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    ea        = signed_op ? {{32{a[31]}}, a} : {32'd0, a};
    eb        = signed_op ? {{32{b[31]}}, b} : {32'd0, b};
    div_zero  = (b == 32'd0);
    // Divisor forced to 1 on divide-by-zero so the divider never sees 0;
    // the result is discarded anyway.
    db        = div_zero ? 64'd1 : eb;
    // Low 64 bits of the product are identical for signed and unsigned
    // once the operands are extended to 64 bits.
    prod      = ea * eb;
    hi_res    = 32'd0;
    lo_res    = 32'd0;
    case (op)
      MD_MULT, MD_MULTU: begin
        hi_res = prod[63:32];
        lo_res = prod[31:0];
      end
      MD_DIV: begin
        // 64-bit signed divide: 0x80000000 / -1 yields +2^31, whose low
        // word is 0x80000000 with remainder 0, no overflow trap needed.
        lo_res = 32'($signed(ea) / $signed(db));
        hi_res = 32'($signed(ea) % $signed(db));
      end
      MD_DIVU: begin
        lo_res = 32'(ea / db);
        hi_res = 32'(ea % db);
      end
      default: begin
        hi_res = 32'd0;
        lo_res = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/e_muldiv_unit.sv
// E-stage multiply/divide unit owning architectural HI/LO.
// Ports: Clk, Rst (sync, active-low), md slave bundle (Start/MDOp/A/B/Req in,
// Busy/HI/LO/Out out). Results land in HI/LO the cycle Busy first drops.
module e_muldiv_unit
  import e_muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  e_muldiv_unit_if.slave   md
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [31:0]        hi_q, hi_nx;
  logic [31:0]        lo_q, lo_nx;
  logic [31:0]        tmp_hi, tmp_hi_nx;
  logic [31:0]        tmp_lo, tmp_lo_nx;
  logic               skip_wr, skip_wr_nx;

  logic [31:0]        core_hi;
  logic [31:0]        core_lo;
  logic               core_div_zero;
  logic               accept;

  e_muldiv_unit_core u_core (
    .op       (md.MDOp),
    .a        (md.A),
    .b        (md.B),
    .hi_res   (core_hi),
    .lo_res   (core_lo),
    .div_zero (core_div_zero)
  );

  // A cancelled (Req) instruction or one arriving while busy is dropped.
  assign accept = md.Start && !md.Req && (state == IDLE);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hi_nx      = hi_q;
    lo_nx      = lo_q;
    tmp_hi_nx  = tmp_hi;
    tmp_lo_nx  = tmp_lo;
    skip_wr_nx = skip_wr;
    case (state)
      IDLE: begin
        if (accept) begin
          case (md.MDOp)
            MD_MULT, MD_MULTU: begin
              tmp_hi_nx  = core_hi;
              tmp_lo_nx  = core_lo;
              skip_wr_nx = 1'b0;
              cnt_nx     = CNT_W'(MULT_CYCLES);
              state_nx   = RUN;
            end
            MD_DIV, MD_DIVU: begin
              tmp_hi_nx  = core_hi;
              tmp_lo_nx  = core_lo;
              skip_wr_nx = core_div_zero;
              cnt_nx     = CNT_W'(DIV_CYCLES);
              state_nx   = RUN;
            end
            MD_MTHI: hi_nx = md.A;
            MD_MTLO: lo_nx = md.A;
            default: begin
            end
          endcase
        end
      end
      RUN: begin
        // Req is ignored here: the issuing instruction already left E.
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          if (!skip_wr) begin
            hi_nx = tmp_hi;
            lo_nx = tmp_lo;
          end
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      tmp_hi  <= '0;
      tmp_lo  <= '0;
      skip_wr <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      hi_q    <= hi_nx;
      lo_q    <= lo_nx;
      tmp_hi  <= tmp_hi_nx;
      tmp_lo  <= tmp_lo_nx;
      skip_wr <= skip_wr_nx;
    end
  end

  assign md.Busy = (state == RUN);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

  // mf reads the current architectural value; same-cycle completions are
  // not bypassed.
  always_comb begin
    md.Out = 32'd0;
    case (md.MDOp)
      MD_MFHI: md.Out = hi_q;
      MD_MFLO: md.Out = lo_q;
      default: md.Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_muldiv_unit.sv
module tb_e_muldiv_unit;
  import e_muldiv_unit_pkg::*;

  logic Clk;
  logic Rst;
  int   n_chk;
  int   n_fail;

  e_muldiv_unit_if ifc ();

  e_muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .md  (ifc.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_cyc;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one instruction for one cycle; returns at the following negedge.
  task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic req);
    @(negedge Clk);
    chk("start_while_busy", {31'd0, ifc.Busy}, 32'd0);
    ifc.Start = 1'b1;
    ifc.MDOp  = op;
    ifc.A     = a;
    ifc.B     = b;
    ifc.Req   = req;
    @(negedge Clk);
    ifc.Start = 1'b0;
    ifc.MDOp  = MD_NONE;
    ifc.A     = 32'd0;
    ifc.B     = 32'd0;
    ifc.Req   = 1'b0;
  endtask

  // Count negedges with Busy high, bounded.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (ifc.Busy && cyc < 200) begin
      cyc++;
      @(negedge Clk);
    end
  endtask

  initial begin
    int cyc;
    n_chk  = 0;
    n_fail = 0;
    ifc.Start = 1'b0;
    ifc.MDOp  = MD_NONE;
    ifc.A     = 32'd0;
    ifc.B     = 32'd0;
    ifc.Req   = 1'b0;
    Rst = 1'b0;

    vecs[0]  = '{MD_MTHI,  32'h12345678, 32'h0,        0,  32'h12345678, 32'h00000000};
    vecs[1]  = '{MD_MTLO,  32'h9ABCDEF0, 32'h0,        0,  32'h12345678, 32'h9ABCDEF0};
    vecs[2]  = '{MD_MULT,  32'hFFFFFFFE, 32'h3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[3]  = '{MD_MULTU, 32'hFFFFFFFE, 32'h3,        5,  32'h00000002, 32'hFFFFFFFA};
    vecs[4]  = '{MD_DIV,   32'hFFFFFFF9, 32'h2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[6]  = '{MD_MTHI,  32'h00000011, 32'h0,        0,  32'h00000011, 32'h80000000};
    vecs[7]  = '{MD_MTLO,  32'h00000022, 32'h0,        0,  32'h00000011, 32'h00000022};
    vecs[8]  = '{MD_DIVU,  32'h00000005, 32'h0,        10, 32'h00000011, 32'h00000022};
    vecs[9]  = '{MD_DIVU,  32'h00000064, 32'h7,        10, 32'h00000002, 32'h0000000E};
    vecs[10] = '{MD_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
    vecs[11] = '{MD_MFLO,  32'h12345678, 32'h1,        0,  32'h40000000, 32'h00000000};
    vecs[12] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};

    repeat (3) @(negedge Clk);
    chk("reset_busy", {31'd0, ifc.Busy}, 32'd0);
    chk("reset_hi", ifc.HI, 32'd0);
    chk("reset_lo", ifc.LO, 32'd0);
    Rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      wait_idle(cyc);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d_hi", i), ifc.HI, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), ifc.LO, vecs[i].exp_lo);
    end

    // mf reads: HI=1, LO=0xFFFFFFFD after the last vector.
    ifc.MDOp = MD_MFHI;
    #1 chk("mfhi_out", ifc.Out, 32'h00000001);
    ifc.MDOp = MD_MFLO;
    #1 chk("mflo_out", ifc.Out, 32'hFFFFFFFD);
    ifc.MDOp = MD_NONE;
    #1 chk("none_out", ifc.Out, 32'h00000000);

    // Cancelled MULT and MTLO leave everything untouched.
    issue(MD_MULT, 32'h00000010, 32'h00000010, 1'b1);
    chk("req_mult_busy", {31'd0, ifc.Busy}, 32'd0);
    chk("req_mult_hi", ifc.HI, 32'h00000001);
    chk("req_mult_lo", ifc.LO, 32'hFFFFFFFD);
    issue(MD_MTLO, 32'hDEADBEEF, 32'h0, 1'b1);
    chk("req_mtlo_busy", {31'd0, ifc.Busy}, 32'd0);
    chk("req_mtlo_lo", ifc.LO, 32'hFFFFFFFD);

    // Req during RUN does not abort the divide.
    issue(MD_DIV, 32'hFFFFFFF9, 32'h2, 1'b0);
    cyc = 0;
    repeat (3) begin
      cyc++;
      @(negedge Clk);
    end
    ifc.Req = 1'b1;
    repeat (2) begin
      cyc++;
      @(negedge Clk);
    end
    ifc.Req = 1'b0;
    while (ifc.Busy && cyc < 200) begin
      cyc++;
      @(negedge Clk);
    end
    chk("req_run_cycles", 32'(cyc), 32'd10);
    chk("req_run_hi", ifc.HI, 32'hFFFFFFFF);
    chk("req_run_lo", ifc.LO, 32'hFFFFFFFD);

    // Reset in the middle of a MULT, then a fresh MULTU.
    issue(MD_MULT, 32'h00000100, 32'h00000100, 1'b0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_mid_busy", {31'd0, ifc.Busy}, 32'd0);
    chk("rst_mid_hi", ifc.HI, 32'd0);
    chk("rst_mid_lo", ifc.LO, 32'd0);
    Rst = 1'b1;
    issue(MD_MULTU, 32'h00000007, 32'h00000006, 1'b0);
    wait_idle(cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd5);
    chk("post_rst_hi", ifc.HI, 32'h00000000);
    chk("post_rst_lo", ifc.LO, 32'h0000002A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
